// File: rtl/sipo_rx_if.sv
// sipo_rx_if -- handshake bundle for the serial-in / parallel-out receiver.
//   master : drives bit_in, bit_valid, clear, data_ready; observes results
//   slave  : the receiver; drives data_out, data_valid, overrun,
//            parity_err, busy
interface sipo_rx_if;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    modport master (
        output bit_in, bit_valid, clear, data_ready,
        input  data_out, data_valid, overrun, parity_err, busy
    );

    modport slave (
        input  bit_in, bit_valid, clear, data_ready,
        output data_out, data_valid, overrun, parity_err, busy
    );
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx -- serial-in, parallel-out byte receiver with a one-entry output
// register and valid/ready handoff to the consumer.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : sipo_rx_if.slave
//          bit_in/bit_valid  serial bit stream, LSB first
//          clear             abort partial frame, clear overrun
//          data_out/valid    assembled byte, held until accepted (data_ready)
//          overrun           sticky: a completed frame was dropped
//          parity_err        parity result for the byte in data_out
//          busy              a partial frame is in progress
//
// Optional feature: define SIPO_PARITY_EN for 9-bit frames (8 data bits then
// an even-parity bit). Without it frames are 8 bits and parity_err is 0.
module sipo_rx (
    input  logic       clk,
    input  logic       rst,
    sipo_rx_if.slave   bus
);

`ifdef SIPO_PARITY_EN
    localparam logic [3:0] LAST_CNT = 4'd8;
`else
    localparam logic [3:0] LAST_CNT = 4'd7;
`endif

    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] data_q,  data_d;
    logic       dv_q,    dv_d;
    logic       ovr_q,   ovr_d;

    logic       sample;
    logic       last;
    logic       xfer;
    logic       drop;
    logic [7:0] frame_byte;

    // clear wins over bit_valid on the same edge
    assign sample = bus.bit_valid && !bus.clear;
    assign last   = sample && (cnt_q == LAST_CNT);
    // output slot is free if empty or being drained on this same edge
    assign xfer   = last && (!dv_q || bus.data_ready);
    assign drop   = last && dv_q && !bus.data_ready;

`ifdef SIPO_PARITY_EN
    // final bit is parity; the byte is already fully in the shift register
    assign frame_byte = shift_q;
`else
    assign frame_byte = {bus.bit_in, shift_q[7:1]};
`endif

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dv_d    = dv_q;
        ovr_d   = ovr_q;

        if (bus.clear) begin
            shift_d = 8'h00;
            cnt_d   = 4'd0;
            ovr_d   = 1'b0;
        end else if (sample) begin
`ifdef SIPO_PARITY_EN
            // parity bit never enters the data path
            if (cnt_q != LAST_CNT)
                shift_d = {bus.bit_in, shift_q[7:1]};
`else
            shift_d = {bus.bit_in, shift_q[7:1]};
`endif
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
        end

        if (drop)
            ovr_d = 1'b1;

        if (xfer) begin
            data_d = frame_byte;
            dv_d   = 1'b1;
        end else if (dv_q && bus.data_ready) begin
            dv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= 8'h00;
            cnt_q   <= 4'd0;
            data_q  <= 8'h00;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic perr_q;

    // even parity: data XOR parity bit must be 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perr_q <= 1'b0;
        else if (xfer)
            perr_q <= (^shift_q) ^ bus.bit_in;
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (cnt_q != 4'd0);

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx -- self-checking bench for sipo_rx. Expected bytes are queued
// when a frame is driven and popped when the receiver presents a byte.
module tb_sipo_rx;

`ifdef SIPO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    sipo_rx_if bus();

    sipo_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives one frame; p is the parity bit used only in 9-bit frames
    task automatic send_byte(input logic [7:0] b, input logic p,
                             input bit gap, input bit chk_busy);
        for (int i = 0; i < FL; i++) begin
            bus.bit_in    = (i < 8) ? b[i] : p;
            bus.bit_valid = 1'b1;
            step();
            if (chk_busy) begin
                total++;
                if (bus.busy !== (i != FL - 1)) begin
                    bad++;
                    $display("FAIL busy bit%0d: got %b want %b", i, bus.busy, (i != FL - 1));
                end
            end
            if (gap) begin
                bus.bit_valid = 1'b0;
                step();
            end
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic drain();
        bus.data_ready = 1'b1;
        step();
        bus.data_ready = 1'b0;
        total++;
        if (bus.data_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain valid: got %b want 0", bus.data_valid);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.parity_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: got out=%h v=%b o=%b p=%b b=%b want 00 0 0 0 0",
                     bus.data_out, bus.data_valid, bus.overrun, bus.parity_err, bus.busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ^8'hA5, 1'b0, 1'b0);
        exp_b = exp_q.pop_front();
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp_b) begin
            bad++;
            $display("FAIL single: got v=%b out=%h want 1 %h", bus.data_valid, bus.data_out, exp_b);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.parity_err !== 1'b0) begin
            bad++;
            $display("FAIL single flags: got b=%b o=%b p=%b want 0 0 0",
                     bus.busy, bus.overrun, bus.parity_err);
        end
        drain();
    endtask

    task automatic test_gap();
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, ^8'h3C, 1'b1, 1'b1);
        exp_b = exp_q.pop_front();
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp_b) begin
            bad++;
            $display("FAIL gap: got v=%b out=%h want 1 %h", bus.data_valid, bus.data_out, exp_b);
        end
        drain();
    endtask

    task automatic test_overrun();
        exp_q.push_back(8'h11);
        send_byte(8'h11, ^8'h11, 1'b0, 1'b0);
        send_byte(8'h22, ^8'h22, 1'b0, 1'b0);   // dropped: slot still full
        exp_b = exp_q.pop_front();
        total++;
        if (bus.data_out !== exp_b || bus.overrun !== 1'b1 || bus.data_valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun: got out=%h o=%b v=%b want %h 1 1",
                     bus.data_out, bus.overrun, bus.data_valid, exp_b);
        end
        step();
        total++;
        if (bus.overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun sticky: got %b want 1", bus.overrun);
        end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        total++;
        if (bus.overrun !== 1'b0 || bus.data_valid !== 1'b1 || bus.data_out !== exp_b) begin
            bad++;
            $display("FAIL clear: got o=%b v=%b out=%h want 0 1 %h",
                     bus.overrun, bus.data_valid, bus.data_out, exp_b);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [7:0] b;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        bus.data_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = bytes[k];
            exp_q.push_back(b);
            for (int i = 0; i < FL; i++) begin
                bus.bit_in    = (i < 8) ? b[i] : ^b;
                bus.bit_valid = 1'b1;
                step();
                total++;
                if (i == FL - 1) begin
                    exp_b = exp_q.pop_front();
                    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_b || bus.overrun !== 1'b0) begin
                        bad++;
                        $display("FAIL b2b byte%0d: got v=%b out=%h o=%b want 1 %h 0",
                                 k, bus.data_valid, bus.data_out, bus.overrun, exp_b);
                    end
                end else if (bus.data_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b hold byte%0d bit%0d: got v=%b want 0", k, i, bus.data_valid);
                end
            end
        end
        bus.bit_valid = 1'b0;
        step();
        bus.data_ready = 1'b0;
        total++;
        if (bus.data_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b tail: got v=%b o=%b want 0 0", bus.data_valid, bus.overrun);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] ff;
        ff = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            bus.bit_in    = ff[i];
            bus.bit_valid = 1'b1;
            step();
        end
        bus.bit_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL partial busy: got %b want 1", bus.busy);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL async rst: got b=%b v=%b out=%h want 0 0 00",
                     bus.busy, bus.data_valid, bus.data_out);
        end
        rst = 1'b1;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, ^8'h5A, 1'b0, 1'b0);
        exp_b = exp_q.pop_front();
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp_b) begin
            bad++;
            $display("FAIL after rst: got v=%b out=%h want 1 %h", bus.data_valid, bus.data_out, exp_b);
        end
        drain();
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        send_byte(8'h07, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.data_out !== 8'h07 || bus.parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity good: got out=%h p=%b want 07 0", bus.data_out, bus.parity_err);
        end
        drain();
        send_byte(8'h07, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.data_out !== 8'h07 || bus.parity_err !== 1'b1) begin
            bad++;
            $display("FAIL parity bad: got out=%h p=%b want 07 1", bus.data_out, bus.parity_err);
        end
        drain();
    endtask
`endif

    initial begin
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.clear      = 1'b0;
        bus.data_ready = 1'b0;
        test_reset();
        test_single();
        test_gap();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
